// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for a 2-input gate: sweeps {a,b} through 0..3, compares y to TRUTH.
// Optional first-mismatch capture ports are built when GATE_VECTOR_CHECKER_FIRST_FAIL_EN is defined.
module gate_vector_checker #(
    parameter logic [3:0] TRUTH         = 4'b1000,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         NUM_PASSES    = 1,
    parameter int         ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             y_in,
    output logic [1:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
   ,output logic             fail_valid,
    output logic [1:0]       fail_vec,
    output logic             fail_y
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
    localparam logic [7:0] LAST_PASS   = 8'(NUM_PASSES - 1);

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic             a_q, a_d, b_q, b_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [7:0]       settle_q, settle_d;
    logic             mismatch;
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
    logic             fvld_q, fvld_d;
    logic [1:0]       fvec_q, fvec_d;
    logic             fy_q, fy_d;
`endif

    // Case inequality so X/Z on y_in is always counted as a mismatch in simulation.
    assign mismatch = (y_in !== TRUTH[vec_q]);

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        pcnt_d   = pcnt_q;
        settle_d = settle_q;
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
        fvld_d   = fvld_q;
        fvec_d   = fvec_q;
        fy_d     = fy_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d   = '0;
                    vec_d   = 2'd0;
                    pcnt_d  = 8'd0;
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
                    fvld_d  = 1'b0;
                    fvec_d  = 2'd0;
                    fy_d    = 1'b0;
`endif
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                a_d      = vec_q[1];
                b_d      = vec_q[0];
                settle_d = SETTLE_LAST;
                state_d  = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
            end
            S_SETTLE: begin
                if (settle_q == 8'd0) state_d = S_CHECK;
                else                  settle_d = settle_q - 8'd1;
            end
            S_CHECK: begin
                if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
                if (mismatch && !fvld_q) begin
                    fvld_d = 1'b1;
                    fvec_d = vec_q;
                    fy_d   = (y_in === 1'b1);
                end
`endif
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = S_DRIVE;
                end else if (pcnt_q != LAST_PASS) begin
                    vec_d   = 2'd0;
                    pcnt_d  = pcnt_q + 8'd1;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= 2'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            err_q    <= '0;
            pcnt_q   <= 8'd0;
            settle_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            a_q      <= a_d;
            b_q      <= b_d;
            err_q    <= err_d;
            pcnt_q   <= pcnt_d;
            settle_q <= settle_d;
        end
    end

`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fvld_q <= 1'b0;
            fvec_q <= 2'd0;
            fy_q   <= 1'b0;
        end else begin
            fvld_q <= fvld_d;
            fvec_q <= fvec_d;
            fy_q   <= fy_d;
        end
    end

    assign fail_valid = fvld_q;
    assign fail_vec   = fvec_q;
    assign fail_y     = fy_q;
`endif

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign vec_idx   = vec_q;
    assign busy      = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: four configurations, each checking a behavioural gate model.
module tb_gate_vector_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Gate model modes: 0 AND, 1 stuck-at-0, 2 stuck-at-1, 3 XOR.
    logic [3:0][1:0] mode;
    logic [3:0]      start_r, a_w, b_w, y_w, busy_w, done_w, pass_w;
    logic [3:0][1:0] vi_w;
    logic [3:0][7:0] err_w;
    logic [1:0]      err2;
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
    logic [3:0]      fvld_w, fy_w;
    logic [3:0][1:0] fvec_w;
`endif

    function automatic logic gate(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return a & b;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        y_w = '0;
        for (int i = 0; i < 4; i++) y_w[i] = gate(mode[i], a_w[i], b_w[i]);
    end

    assign err_w[2] = {6'd0, err2};

    // u0 defaults, u1 two passes, u2 two passes with 2-bit counter, u3 XOR truth with no settle.
    gate_vector_checker u0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .a_out(a_w[0]), .b_out(b_w[0]), .y_in(y_w[0]),
        .vec_idx(vi_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0])
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
       ,.fail_valid(fvld_w[0]), .fail_vec(fvec_w[0]), .fail_y(fy_w[0])
`endif
    );
    gate_vector_checker #(.NUM_PASSES(2)) u1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .a_out(a_w[1]), .b_out(b_w[1]), .y_in(y_w[1]),
        .vec_idx(vi_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1])
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
       ,.fail_valid(fvld_w[1]), .fail_vec(fvec_w[1]), .fail_y(fy_w[1])
`endif
    );
    gate_vector_checker #(.NUM_PASSES(2), .ERR_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start_r[2]), .a_out(a_w[2]), .b_out(b_w[2]), .y_in(y_w[2]),
        .vec_idx(vi_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err2)
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
       ,.fail_valid(fvld_w[2]), .fail_vec(fvec_w[2]), .fail_y(fy_w[2])
`endif
    );
    gate_vector_checker #(.TRUTH(4'b0110), .SETTLE_CYCLES(0)) u3 (
        .clk(clk), .rst(rst), .start(start_r[3]), .a_out(a_w[3]), .b_out(b_w[3]), .y_in(y_w[3]),
        .vec_idx(vi_w[3]), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_count(err_w[3])
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
       ,.fail_valid(fvld_w[3]), .fail_vec(fvec_w[3]), .fail_y(fy_w[3])
`endif
    );

    typedef struct {
        int         dut;
        logic [1:0] md;
        int         err;
        bit         pass;
        int         cyc;   // edges from the start edge until done is seen
        bit         poke;  // pulse start again while busy
        bit         fvld;
        int         fvec;
        bit         fy;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[9];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 3) ? 0 : 2;
    endfunction

    function automatic int outs(input int d);
        return {25'd0, a_w[d], b_w[d], vi_w[d], busy_w[d], done_w[d], pass_w[d]} | (int'(err_w[d]) << 8);
    endfunction

    task automatic run(input vec_t t);
        int   d  = t.dut;
        int   sp = settle_of(t.dut) + 2;
        int   e  = 0;
        bit   seen = 0;
        vec_t x;
        mode[d] = t.md;
        sb.push_back(t);
        @(negedge clk) start_r[d] = 1'b1;
        @(negedge clk) start_r[d] = 1'b0;
        chk("start_clear", {busy_w[d], done_w[d], vi_w[d], err_w[d]}, 12'h800);
        while (!seen && e < t.cyc + 20) begin
            if (t.poke && e == 5) start_r[d] = 1'b1;
            @(negedge clk);
            start_r[d] = 1'b0;
            e++;
            if (done_w[d]) seen = 1;
            else chk($sformatf("step%0d_e%0d", d, e), {busy_w[d], a_w[d], b_w[d], vi_w[d]},
                     16 + (((e - 1) / sp) % 4) * 4 + (e / sp) % 4);
        end
        x = sb.pop_front();
        if (!seen) begin
            chk($sformatf("timeout_dut%0d", d), 0, 1);
        end else begin
            chk($sformatf("run_len_dut%0d", d), e, x.cyc);
            chk($sformatf("err_dut%0d", d), int'(err_w[d]), x.err);
            chk($sformatf("pass_dut%0d", d), int'(pass_w[d]), int'(x.pass));
            chk($sformatf("done_hold_dut%0d", d), {busy_w[d], a_w[d], b_w[d], vi_w[d]}, 5'b01111);
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
            chk($sformatf("fvld_dut%0d", d), int'(fvld_w[d]), int'(x.fvld));
            if (x.fvld) begin
                chk($sformatf("fvec_dut%0d", d), int'(fvec_w[d]), x.fvec);
                chk($sformatf("fy_dut%0d", d), int'(fy_w[d]), int'(x.fy));
            end
`endif
        end
        // done must stay put while start is idle
        repeat (3) @(negedge clk);
        chk($sformatf("done_stable_dut%0d", d), {done_w[d], pass_w[d]}, {1'b1, x.pass});
    endtask

    initial begin
        //            dut md   err pass cyc poke fvld fvec fy
        tbl[0] = '{0, 2'd0, 0, 1'b1, 16, 1'b0, 1'b0, 0, 1'b0};
        tbl[1] = '{0, 2'd1, 1, 1'b0, 16, 1'b1, 1'b1, 3, 1'b0};
        tbl[2] = '{0, 2'd2, 3, 1'b0, 16, 1'b0, 1'b1, 0, 1'b1};
        tbl[3] = '{0, 2'd3, 3, 1'b0, 16, 1'b0, 1'b1, 1, 1'b1};
        tbl[4] = '{1, 2'd2, 6, 1'b0, 32, 1'b1, 1'b1, 0, 1'b1};
        tbl[5] = '{2, 2'd2, 3, 1'b0, 32, 1'b0, 1'b1, 0, 1'b1};
        tbl[6] = '{3, 2'd3, 0, 1'b1,  8, 1'b0, 1'b0, 0, 1'b0};
        tbl[7] = '{3, 2'd0, 3, 1'b0,  8, 1'b1, 1'b1, 1, 1'b0};
        tbl[8] = '{0, 2'd0, 0, 1'b1, 16, 1'b1, 1'b0, 0, 1'b0};

        mode    = '0;
        start_r = '0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("reset_dut%0d", i), outs(i), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run(tbl[i]);

        // Asynchronous reset in the middle of vector 2's settle window.
        mode[0] = 2'd2;
        @(negedge clk) start_r[0] = 1'b1;
        @(negedge clk) start_r[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_state", {busy_w[0], vi_w[0], err_w[0]}, {1'b1, 2'd2, 8'd2});
        rst = 1'b1;
        #1;
        chk("async_rst_outs", outs(0), 0);
`ifdef GATE_VECTOR_CHECKER_FIRST_FAIL_EN
        chk("async_rst_fail", {fvld_w[0], fvec_w[0], fy_w[0]}, 0);
`endif
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", outs(0), 0);
        run(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
